mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle control FSM for the next-generation MIPS core. It replaces the single-cycle combinational decode with a sequenced controller that steps each instruction through fetch, decode, execute, memory and writeback states. It handshakes with a variable-latency unified memory, and keeps a retired-instruction counter whose width is set by a parameter. It sits between the instruction register and the datapath muxes, register-file enables and memory request port.

## Interface
- CNT_WIDTH, 32, width of retired-instruction counter
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepts/completes request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid with mem_req
- iord  out  1  address select: 0 PC, 1 ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- reg_write  out  1  register file write enable
- reg_dst  out  2  0 rt, 1 rd, 2 $ra
- mem_to_reg  out  2  0 ALUOut, 1 MDR, 2 PC (return address)
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  0 B, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 use funct
- pc_src  out  2  0 ALU result, 1 ALUOut, 2 jump target, 3 A (jr)
- syscall  out  1  one-cycle syscall pulse
- illegal  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state encoding (debug)
- retired  out  CNT_WIDTH  instructions completed since reset

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, RTWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, JR 12, SYSC 13, JAL 14.
- Decoded opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, j 0x02, jal 0x03. For R-type, funct 0x08 is jr and funct 0x0C is syscall.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=00, pc_src=0. ir_write=pc_write=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=00 (branch target into ALUOut).
  - lw/sw go to MEMADR.
  - R-type goes to JR if funct=0x08, to SYSC if funct=0x0C, otherwise to RTEXEC.
  - beq/bne go to BRANCH.
  - j goes to JUMP; jal goes to JAL; addi goes to ADDIEX.
  - Any other opcode pulses illegal and goes to FETCH. It is not counted as retired.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Waits for mem_ready, then goes to FETCH.
- RTEXEC: alu_src_a=1, alu_src_b=0, alu_op=10. Goes to RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_src=1. pc_write = zero for beq, ~zero for bne. Goes to FETCH.
- JUMP: pc_src=2, pc_write=1. Goes to FETCH.
- JAL: pc_src=2, pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2. Goes to FETCH.
- JR: pc_src=3, pc_write=1. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=00. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- SYSC: syscall=1. Goes to FETCH.
- Any output not listed for a state is 0.
- retired increments by 1 on every transition from an instruction's final state to FETCH, except the illegal path. It wraps modulo 2^CNT_WIDTH.
- The opcode/funct inputs are sampled only in DECODE and MEMADR. They are don't-care elsewhere.

## Timing
- Reset, asynchronous: state=FETCH and retired=0 immediately. While reset is high, all outputs are forced to 0, including mem_req. The first mem_req is issued in the cycle after reset deasserts.
- Reset mid-instruction aborts that instruction. No further writes occur and it is not counted.
- All outputs are Moore functions of state, except ir_write and pc_write in FETCH (gated by mem_ready) and pc_write in BRANCH (gated by zero).
- mem_ready may be high in the same cycle mem_req first rises (zero-wait memory). mem_ready outside a memory state is ignored.
- Each cycle of mem_ready=0 in a memory state adds exactly one cycle.
- Zero-wait cycle counts: lw 5; sw, R-type and addi 4; beq, bne, j, jal, jr and syscall 3; illegal 2.
- mem_req and mem_we stay stable throughout a wait; they drop the cycle after mem_ready is sampled high.

## Test plan
- Reset then lw, mem_ready tied high: states 0,1,2,3,4,0. reg_write is high in state 4 only. retired=1 after 5 cycles.
- FETCH with mem_ready low for 3 cycles: mem_req held 4 cycles. ir_write and pc_write pulse exactly once, in the 4th cycle.
- beq with zero=1 gives pc_write=1 in BRANCH. bne with zero=1 gives pc_write=0. Each takes 3 cycles.
- jal: in state 14, pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2. Then jr gives pc_src=3. retired advances by 2.
- Opcode 0x3F: illegal pulses in DECODE, next state is FETCH, and retired is unchanged. syscall (funct 0x0C) pulses syscall for 1 cycle.
- CNT_WIDTH=4: 17 R-type instructions give retired=1 (wrap). Asserting reset during MEMRD gives state=0, retired=0 and mem_req=0 asynchronously.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS control FSM. Sequences each instruction through
// fetch/decode/execute/memory/writeback, handshakes with a variable-latency
// memory and counts retired instructions.
module mc_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_src,
  output logic                 syscall,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEXEC = 4'd6,  RTWB   = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    JR     = 4'd12, SYSC   = 4'd13, JAL    = 4'd14
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_SYSC  = 6'h0C;

  stateT                curState, nextState;
  logic                 isBne;      // opcode is don't-care in BRANCH, so remember beq/bne
  logic                 retireNow;
  logic [CNT_WIDTH-1:0] retiredCnt;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) curState <= FETCH;
    else       curState <= nextState;
  end

  // Capture the branch flavour while the opcode is still valid
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   isBne <= 1'b0;
    else if (curState == DECODE) isBne <= (opcode == OP_BNE);
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          retiredCnt <= '0;
    else if (retireNow) retiredCnt <= retiredCnt + CNT_WIDTH'(1);
  end

  // Any return to FETCH from a final state retires; DECODE->FETCH is the illegal path
  assign retireNow = (nextState == FETCH) && (curState != FETCH) && (curState != DECODE);

  // Next-state and control outputs; everything is held low while reset is high
  always_comb begin
    nextState  = curState;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'b00;
    pc_src     = 2'd0;
    syscall    = 1'b0;
    illegal    = 1'b0;
    unique case (curState)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) nextState = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        unique case (opcode)
          OP_LW, OP_SW:   nextState = MEMADR;
          OP_RTYPE: begin
            if (funct == FN_JR)        nextState = JR;
            else if (funct == FN_SYSC) nextState = SYSC;
            else                       nextState = RTEXEC;
          end
          OP_BEQ, OP_BNE: nextState = BRANCH;
          OP_J:           nextState = JUMP;
          OP_JAL:         nextState = JAL;
          OP_ADDI:        nextState = ADDIEX;
          default: begin
            illegal   = 1'b1;
            nextState = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        nextState = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) nextState = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        nextState  = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) nextState = FETCH;
      end
      RTEXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nextState = RTWB;
      end
      RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
        nextState = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'd1;
        pc_write  = isBne ? ~zero : zero;
        nextState = FETCH;
      end
      JUMP: begin
        pc_src    = 2'd2;
        pc_write  = 1'b1;
        nextState = FETCH;
      end
      JAL: begin
        pc_src     = 2'd2;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        nextState  = FETCH;
      end
      JR: begin
        pc_src    = 2'd3;
        pc_write  = 1'b1;
        nextState = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        nextState = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        nextState = FETCH;
      end
      SYSC: begin
        syscall   = 1'b1;
        nextState = FETCH;
      end
      default: nextState = FETCH;
    endcase
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 2'b00;
      pc_src     = 2'd0;
      syscall    = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state   = reset ? 4'd0 : curState;
  assign retired = retiredCnt;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized instruction stream; the stimulus pushes the expected
// per-cycle state/controls/retired into a queue, a negedge monitor pops and compares.
module tb_mc_control;
  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset;
  logic [5:0] opcode, funct;
  logic zero, mem_ready;
  logic mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
  logic alu_src_a, syscall, illegal;
  logic [3:0] state;
  logic [CW-1:0] retired;

  mc_control #(.CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .syscall(syscall),
    .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]    st;
    logic [18:0]   ctl;
    logic [CW-1:0] ret;
  } expT;

  expT expQ[$];
  int nTests = 0;
  int nFail  = 0;
  int retModel = 0;

  // instruction classes
  localparam int C_LW = 0, C_SW = 1, C_RT = 2, C_JR = 3, C_SYS = 4, C_BEQ = 5,
                 C_BNE = 6, C_J = 7, C_JAL = 8, C_ADDI = 9, C_ILL = 10;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Control word expected for a state, straight from the state table.
  // Order: mem_req,mem_we,iord,ir_write,pc_write,reg_write,reg_dst,mem_to_reg,
  //        alu_src_a,alu_src_b,alu_op,pc_src,syscall,illegal
  function automatic logic [18:0] ctlFor(int st, bit rdy, bit z, bit bne, bit ill);
    logic req = 0, we = 0, io = 0, irw = 0, pcw = 0, rw = 0, sa = 0, sc = 0, il = 0;
    logic [1:0] rd = 0, m2r = 0, sb = 0, op = 0, ps = 0;
    case (st)
      0:  begin req = 1; sb = 1; irw = rdy; pcw = rdy; end
      1:  begin sb = 3; il = ill; end
      2:  begin sa = 1; sb = 2; end
      3:  begin req = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin req = 1; we = 1; io = 1; end
      6:  begin sa = 1; op = 2; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; op = 1; ps = 1; pcw = bne ? !z : z; end
      9:  begin ps = 2; pcw = 1; end
      10: begin sa = 1; sb = 2; end
      11: begin rw = 1; end
      12: begin ps = 3; pcw = 1; end
      13: begin sc = 1; end
      14: begin ps = 2; pcw = 1; rw = 1; rd = 2; m2r = 2; end
      default: ;
    endcase
    return {req, we, io, irw, pcw, rw, rd, m2r, sa, sb, op, ps, sc, il};
  endfunction

  // Monitor: one expected record per clocked cycle out of reset
  always @(negedge clock) begin
    if (!reset && expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("ctl", 32'({mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst,
                      mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, syscall, illegal}),
          32'(e.ctl));
      chk("retired", 32'(retired), 32'(e.ret));
    end
  end

  // Drive one instruction; called at posedge+1. abortAt>=0 asserts reset during
  // that path cycle index (after it has been checked) and returns.
  task automatic runInstr(input int cls, input int fw, input int mw, input bit z,
                          input int abortAt);
    int stq[$];
    bit rdq[$];
    logic [5:0] op, fn;
    bit isIll;
    expT e;
    op = 6'h00;
    fn = 6'(($urandom_range(0, 63)));
    if (fn == 6'h08 || fn == 6'h0C) fn = 6'h20;
    isIll = (cls == C_ILL);
    case (cls)
      C_LW:   op = 6'h23;
      C_SW:   op = 6'h2B;
      C_RT:   op = 6'h00;
      C_JR:   begin op = 6'h00; fn = 6'h08; end
      C_SYS:  begin op = 6'h00; fn = 6'h0C; end
      C_BEQ:  op = 6'h04;
      C_BNE:  op = 6'h05;
      C_J:    op = 6'h02;
      C_JAL:  op = 6'h03;
      C_ADDI: op = 6'h08;
      default: begin
        op = 6'h3F;
        if ($urandom_range(0, 1) == 1) begin
          do op = 6'($urandom_range(0, 63));
          while (op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h03});
        end
      end
    endcase
    for (int i = 0; i <= fw; i++) begin stq.push_back(0); rdq.push_back(i == fw); end
    stq.push_back(1); rdq.push_back(1'($urandom_range(0, 1)));
    case (cls)
      C_LW: begin
        stq.push_back(2); rdq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i <= mw; i++) begin stq.push_back(3); rdq.push_back(i == mw); end
        stq.push_back(4); rdq.push_back(1'($urandom_range(0, 1)));
      end
      C_SW: begin
        stq.push_back(2); rdq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i <= mw; i++) begin stq.push_back(5); rdq.push_back(i == mw); end
      end
      C_RT:   begin stq.push_back(6);  stq.push_back(7);  rdq.push_back(1); rdq.push_back(0); end
      C_JR:   begin stq.push_back(12); rdq.push_back(1); end
      C_SYS:  begin stq.push_back(13); rdq.push_back(0); end
      C_BEQ, C_BNE: begin stq.push_back(8); rdq.push_back(1'($urandom_range(0, 1))); end
      C_J:    begin stq.push_back(9);  rdq.push_back(1); end
      C_JAL:  begin stq.push_back(14); rdq.push_back(0); end
      C_ADDI: begin stq.push_back(10); stq.push_back(11); rdq.push_back(0); rdq.push_back(1); end
      default: ;
    endcase
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int k = 0; k < stq.size(); k++) begin
      mem_ready = rdq[k];
      e.st  = 4'(stq[k]);
      e.ctl = ctlFor(stq[k], rdq[k], z, cls == C_BNE, isIll);
      e.ret = CW'(retModel);
      expQ.push_back(e);
      if (k == abortAt) begin
        #6;                 // past the monitor's sample point, mid-cycle
        reset = 1'b1;
        #1;
        chk("abort state", 32'(state), 32'd0);
        chk("abort mem_req", 32'(mem_req), 32'd0);
        chk("abort retired", 32'(retired), 32'd0);
        retModel = 0;
        return;
      end
      @(posedge clock); #1;
    end
    if (!isIll) retModel = (retModel + 1) % (1 << CW);
  endtask

  task automatic releaseReset();
    @(posedge clock); #1;
    chk("rst held state", 32'(state), 32'd0);
    chk("rst held mem_req", 32'(mem_req), 32'd0);
    @(posedge clock); #1;
    mem_ready = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int cls;
    reset = 1'b1; opcode = 6'h23; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    #1;
    chk("reset state", 32'(state), 32'd0);
    chk("reset retired", 32'(retired), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset ir_write", 32'(ir_write), 32'd0);
    releaseReset();
    // directed prelude: lw zero-wait, fetch with 3 waits, beq/bne zero=1, jal, jr, illegal, syscall
    runInstr(C_LW, 0, 0, 0, -1);
    runInstr(C_RT, 3, 0, 0, -1);
    runInstr(C_BEQ, 0, 0, 1, -1);
    runInstr(C_BNE, 0, 0, 1, -1);
    runInstr(C_JAL, 0, 0, 0, -1);
    runInstr(C_JR, 0, 0, 0, -1);
    runInstr(C_ILL, 0, 0, 0, -1);
    runInstr(C_SYS, 0, 0, 0, -1);
    // every class once, then random; CW=4 makes retired wrap many times
    for (int c = 0; c <= C_ILL; c++)
      runInstr(c, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    for (int n = 0; n < 150; n++) begin
      cls = $urandom_range(0, C_ILL);
      runInstr(cls, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
               1'($urandom_range(0, 1)), -1);
    end
    // abort a load while it waits in MEMRD (path index 3 with zero-wait fetch)
    runInstr(C_LW, 0, 2, 0, 3);
    releaseReset();
    for (int n = 0; n < 20; n++)
      runInstr($urandom_range(0, C_ILL), $urandom_range(0, 1), $urandom_range(0, 1),
               1'($urandom_range(0, 1)), -1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("queue drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  // Hard stop so a broken design can never hang the run
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
